// File: rtl/cube_root_sequencer.sv
// Keypad-driven operand entry and launch/wait/show sequencing for an external
// cube-root datapath, with a timeout watchdog and a clear/hold switch.
module cube_root_sequencer #(
  parameter int unsigned MAX_DIGITS = 6,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic        on3,
  input  logic        reset,
  input  logic        KEY_DIGIT,
  input  logic        KEY_INCREMENT,
  input  logic        KEY_START,
  input  logic        switch,
  output logic        dp_start,
  input  logic        dp_done,
  input  logic [31:0] dp_result,
  output logic [31:0] operand,
  output logic [3:0]  cur_digit,
  output logic        cur_valid,
  output logic [31:0] result,
  output logic        Led,
  output logic        err,
  output logic [2:0]  state
);

  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned DCNT_W = $clog2(MAX_DIGITS + 1);

  localparam logic [2:0] S_ENTRY = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_SHOW  = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [31:0]       operand_q, operand_d;
  logic [31:0]       factor_q, factor_d;
  logic [DCNT_W-1:0] count_q, count_d;
  logic [3:0]        digit_q, digit_d;
  logic              valid_q, valid_d;
  logic [31:0]       result_q, result_d;
  logic              led_q, led_d;
  logic              err_q, err_d;
  logic              dps_q, dps_d;
  logic [CNT_W-1:0]  tmo_q, tmo_d;
  logic              kdig_q, kdig_d;
  logic              kinc_q, kinc_d;
  logic              kst_q, kst_d;

  logic dig_p, inc_p, st_p, commit;

  // Press = previous sample released, current sample pressed.
  assign dig_p = kdig_q & ~KEY_DIGIT;
  assign inc_p = kinc_q & ~KEY_INCREMENT;
  assign st_p  = kst_q  & ~KEY_START;

  // Next-state and datapath-register logic.
  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    factor_d  = factor_q;
    count_d   = count_q;
    digit_d   = digit_q;
    valid_d   = valid_q;
    result_d  = result_q;
    led_d     = led_q;
    err_d     = err_q;
    dps_d     = 1'b0;
    tmo_d     = tmo_q;
    kdig_d    = KEY_DIGIT;
    kinc_d    = KEY_INCREMENT;
    kst_d     = KEY_START;
    commit    = 1'b0;

    if (switch) begin
      state_d   = S_ENTRY;
      operand_d = 32'd0;
      factor_d  = 32'd1;
      count_d   = '0;
      digit_d   = 4'd0;
      valid_d   = 1'b0;
      led_d     = 1'b0;
      err_d     = 1'b0;
      tmo_d     = '0;
    end else begin
      case (state_q)
        S_ENTRY: begin
          if (st_p) begin
            state_d = S_START;
            dps_d   = 1'b1;
          end else begin
            commit = inc_p & valid_q & (count_q < DCNT_W'(MAX_DIGITS));
            if (commit) begin
              operand_d = operand_q + factor_q * 32'(digit_q);
              factor_d  = factor_q * 32'd10;
              count_d   = count_q + DCNT_W'(1);
              valid_d   = 1'b0;
            end
            // A same-cycle commit leaves no pending digit, so the press restarts at 0.
            if (dig_p) begin
              valid_d = 1'b1;
              if (!valid_q || commit) digit_d = 4'd0;
              else if (digit_q == 4'd9) digit_d = 4'd0;
              else digit_d = digit_q + 4'd1;
            end
          end
        end
        S_START: begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (dp_done) begin
            result_d = dp_result;
            led_d    = 1'b1;
            state_d  = S_SHOW;
          end else begin
            tmo_d = tmo_q + CNT_W'(1);
            if (tmo_q == CNT_W'(TIMEOUT - 2)) begin
              err_d   = 1'b1;
              state_d = S_ERROR;
            end
          end
        end
        S_SHOW, S_ERROR: state_d = state_q;
        default: state_d = S_ENTRY;
      endcase
    end
  end

  always_ff @(posedge on3 or posedge reset) begin
    if (reset) begin
      state_q   <= S_ENTRY;
      operand_q <= 32'd0;
      factor_q  <= 32'd1;
      count_q   <= '0;
      digit_q   <= 4'd0;
      valid_q   <= 1'b0;
      result_q  <= 32'd0;
      led_q     <= 1'b0;
      err_q     <= 1'b0;
      dps_q     <= 1'b0;
      tmo_q     <= '0;
      kdig_q    <= 1'b1;
      kinc_q    <= 1'b1;
      kst_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      factor_q  <= factor_d;
      count_q   <= count_d;
      digit_q   <= digit_d;
      valid_q   <= valid_d;
      result_q  <= result_d;
      led_q     <= led_d;
      err_q     <= err_d;
      dps_q     <= dps_d;
      tmo_q     <= tmo_d;
      kdig_q    <= kdig_d;
      kinc_q    <= kinc_d;
      kst_q     <= kst_d;
    end
  end

  assign dp_start  = dps_q;
  assign operand   = operand_q;
  assign cur_digit = digit_q;
  assign cur_valid = valid_q;
  assign result    = result_q;
  assign Led       = led_q;
  assign err       = err_q;
  assign state     = state_q;

endmodule

// File: tb/tb_cube_root_sequencer.sv
// Scoreboard bench for cube_root_sequencer: stimulus queues expected snapshots
// and launch operands; a negedge monitor pops and compares them.
module tb_cube_root_sequencer;

  localparam int unsigned MAXD = 6;
  localparam int unsigned TMO  = 20;

  logic        on3 = 1'b0;
  logic        reset = 1'b1;
  logic        KEY_DIGIT = 1'b1;
  logic        KEY_INCREMENT = 1'b1;
  logic        KEY_START = 1'b1;
  logic        switch = 1'b0;
  logic        dp_start;
  logic        dp_done = 1'b0;
  logic [31:0] dp_result = 32'd0;
  logic [31:0] operand;
  logic [3:0]  cur_digit;
  logic        cur_valid;
  logic [31:0] result;
  logic        Led;
  logic        err;
  logic [2:0]  state;

  cube_root_sequencer #(.MAX_DIGITS(MAXD), .TIMEOUT(TMO)) dut (
    .on3(on3), .reset(reset), .KEY_DIGIT(KEY_DIGIT), .KEY_INCREMENT(KEY_INCREMENT),
    .KEY_START(KEY_START), .switch(switch), .dp_start(dp_start), .dp_done(dp_done),
    .dp_result(dp_result), .operand(operand), .cur_digit(cur_digit), .cur_valid(cur_valid),
    .result(result), .Led(Led), .err(err), .state(state)
  );

  always #5 on3 = ~on3;

  typedef struct {
    string       name;
    logic [2:0]  st;
    logic [31:0] opnd;
    logic [3:0]  dig;
    logic        vld;
    logic [31:0] res;
    logic        led;
    logic        e;
  } snap_t;

  snap_t       exp_q[$];
  logic [31:0] dps_q[$];
  snap_t       mon_s;
  logic [31:0] mon_op;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic tick();
    @(posedge on3);
    #1;
  endtask

  task automatic expect_snap(input string name, input int st, input int unsigned op,
                             input int dg, input int vl, input int unsigned rs,
                             input int ld, input int er);
    snap_t s;
    s.name = name;
    s.st   = 3'(st);
    s.opnd = 32'(op);
    s.dig  = 4'(dg);
    s.vld  = 1'(vl);
    s.res  = 32'(rs);
    s.led  = 1'(ld);
    s.e    = 1'(er);
    exp_q.push_back(s);
  endtask

  task automatic press(input logic d, input logic i, input logic s);
    KEY_DIGIT = ~d;
    KEY_INCREMENT = ~i;
    KEY_START = ~s;
    tick();
    KEY_DIGIT = 1'b1;
    KEY_INCREMENT = 1'b1;
    KEY_START = 1'b1;
    tick();
  endtask

  task automatic clear();
    switch = 1'b1;
    tick();
    switch = 1'b0;
    tick();
  endtask

  // Monitor: every launch pulse must match a queued operand; snapshots are compared whole.
  always @(negedge on3) begin
    if (dp_start === 1'b1) begin
      n_chk++;
      if (dps_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_dp_start operand=%0d (no launch expected)", operand);
      end else begin
        mon_op = dps_q.pop_front();
        if (operand !== mon_op) begin
          n_fail++;
          $display("FAIL dp_start_operand got=%0d expected=%0d", operand, mon_op);
        end
      end
    end
    while (exp_q.size() > 0) begin
      mon_s = exp_q.pop_front();
      n_chk++;
      if ({state, operand, cur_digit, cur_valid, result, Led, err} !==
          {mon_s.st, mon_s.opnd, mon_s.dig, mon_s.vld, mon_s.res, mon_s.led, mon_s.e}) begin
        n_fail++;
        $display("FAIL %s got st=%0d op=%0d dig=%0d vld=%0b res=%0d led=%0b err=%0b expected st=%0d op=%0d dig=%0d vld=%0b res=%0d led=%0b err=%0b",
                 mon_s.name, state, operand, cur_digit, cur_valid, result, Led, err,
                 mon_s.st, mon_s.opnd, mon_s.dig, mon_s.vld, mon_s.res, mon_s.led, mon_s.e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t, run did not complete", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge on3);
    #1;
    expect_snap("reset_values", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();

    // Digit entry, LSD first: 2 then 1 -> 12
    repeat (3) press(1'b1, 1'b0, 1'b0);
    expect_snap("digit_x3", 0, 0, 2, 1, 0, 0, 0);
    press(1'b0, 1'b1, 1'b0);
    expect_snap("commit_2", 0, 2, 2, 0, 0, 0, 0);
    repeat (2) press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    expect_snap("operand_12", 0, 12, 1, 0, 0, 0, 0);
    KEY_DIGIT = 1'b0;
    repeat (3) tick();
    KEY_DIGIT = 1'b1;
    tick();
    expect_snap("held_key_once", 0, 12, 0, 1, 0, 0, 0);

    // Digit wrap sequence and commit with nothing pending
    clear();
    expect_snap("switch_clear", 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) begin
      press(1'b1, 1'b0, 1'b0);
      expect_snap($sformatf("digit_seq_%0d", i), 0, 0, i % 10, 1, 0, 0, 0);
    end
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    expect_snap("incr_no_pending", 0, 1, 1, 0, 0, 0, 0);

    // Enter 27, launch, dp_done 5 cycles after dp_start
    clear();
    repeat (8) press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    repeat (3) press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    expect_snap("operand_27", 0, 27, 2, 0, 0, 0, 0);
    dps_q.push_back(32'd27);
    KEY_START = 1'b0;
    tick();
    KEY_START = 1'b1;
    expect_snap("start_state", 1, 27, 2, 0, 0, 0, 0);
    repeat (4) tick();
    expect_snap("wait_holds_operand", 2, 27, 2, 0, 0, 0, 0);
    tick();
    dp_done = 1'b1;
    dp_result = 32'd3;
    tick();
    dp_done = 1'b0;
    expect_snap("show_result_3", 3, 27, 2, 0, 3, 1, 0);
    press(1'b1, 1'b1, 1'b1);
    expect_snap("show_keys_ignored", 3, 27, 2, 0, 3, 1, 0);

    // Timeout: ERROR exactly TMO cycles after dp_start, result held through clear
    clear();
    expect_snap("clear_keeps_result", 0, 0, 0, 0, 3, 0, 0);
    dps_q.push_back(32'd0);
    KEY_START = 1'b0;
    tick();
    KEY_START = 1'b1;
    repeat (TMO - 1) tick();
    expect_snap("wait_before_timeout", 2, 0, 0, 0, 3, 0, 0);
    tick();
    expect_snap("timeout_error", 4, 0, 0, 0, 3, 0, 1);
    dp_done = 1'b1;
    dp_result = 32'd99;
    tick();
    dp_done = 1'b0;
    expect_snap("error_ignores_done", 4, 0, 0, 0, 3, 0, 1);
    switch = 1'b1;
    tick();
    expect_snap("switch_clears_err", 0, 0, 0, 0, 3, 0, 0);
    KEY_DIGIT = 1'b0;
    tick();
    KEY_DIGIT = 1'b1;
    tick();
    expect_snap("switch_blocks_keys", 0, 0, 0, 0, 3, 0, 0);
    switch = 1'b0;
    tick();

    // dp_done in the last WAIT cycle beats the timeout
    dps_q.push_back(32'd0);
    KEY_START = 1'b0;
    tick();
    KEY_START = 1'b1;
    repeat (TMO - 1) tick();
    dp_done = 1'b1;
    dp_result = 32'd5;
    tick();
    dp_done = 1'b0;
    expect_snap("done_at_limit", 3, 0, 0, 0, 5, 1, 0);

    // Seventh digit ignored at MAX_DIGITS
    clear();
    for (int d = 1; d <= 7; d++) begin
      repeat (d + 1) press(1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b1, 1'b0);
    end
    expect_snap("max_digits", 0, 654321, 7, 1, 5, 0, 0);

    // Simultaneous INCREMENT+DIGIT with pending 4
    clear();
    repeat (5) press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b1, 1'b0);
    expect_snap("simul_incr_digit", 0, 4, 0, 1, 5, 0, 0);

    // START wins over same-cycle DIGIT/INCREMENT
    dps_q.push_back(32'd4);
    KEY_START = 1'b0;
    KEY_DIGIT = 1'b0;
    KEY_INCREMENT = 1'b0;
    tick();
    KEY_START = 1'b1;
    KEY_DIGIT = 1'b1;
    KEY_INCREMENT = 1'b1;
    expect_snap("start_priority", 1, 4, 0, 1, 5, 0, 0);
    repeat (2) tick();
    expect_snap("wait_again", 2, 4, 0, 1, 5, 0, 0);

    // Asynchronous reset pulse between edges during WAIT
    @(posedge on3);
    #2;
    expect_snap("async_reset", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
    dp_done = 1'b1;
    dp_result = 32'd7;
    tick();
    dp_done = 1'b0;
    expect_snap("late_done_ignored", 0, 0, 0, 0, 0, 0, 0);
    repeat (4) tick();

    n_chk++;
    if (exp_q.size() != 0 || dps_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got pending_snapshots=%0d pending_launches=%0d expected 0 and 0",
               exp_q.size(), dps_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
